// File: rtl/bnn_sequencer.sv
// Host-side sequencer for tiny_bnn: serialises parameter bytes onto param_in,
// presents inference input as two nibble bank phases, and returns the captured bnn_out.
module bnn_sequencer #(
  parameter int PARAM_BITS = 64,
  parameter int SETTLE     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic [7:0] cfg_byte,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       params_loaded,
  input  logic [7:0] x_data,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [7:0] y_data,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       busy,
  output logic       bnn_setup,
  output logic       bnn_param_in,
  output logic       bnn_x_bank_hi,
  output logic [3:0] bnn_x,
  input  logic [7:0] bnn_out
);

  localparam int BYTES = PARAM_BITS / 8;
  localparam int BW    = $clog2(BYTES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] READY  = 3'd2;
  localparam logic [2:0] X_LO   = 3'd3;
  localparam logic [2:0] X_HI   = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] RESULT = 3'd6;

  logic [2:0]    state, state_n;
  logic [BW-1:0] bytes_left, bytes_left_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [3:0]    x_hi, x_hi_n;
  logic [3:0]    wait_cnt, wait_n;
  logic          x_ready_q;
  logic          setup_n, param_n, loaded_n, bank_n, y_valid_n;
  logic [3:0]    x_n;
  logic [7:0]    y_data_n;
  logic          cfg_hs, x_hs;

  // A simultaneous cfg_start must withdraw the READY-state x_ready so the
  // host never sees an input handshake that the load then discards.
  assign x_ready = x_ready_q & ~cfg_start;
  assign cfg_hs  = cfg_valid & cfg_ready;
  assign x_hs    = x_valid & x_ready;

  always_comb begin
    state_n      = state;
    bytes_left_n = bytes_left;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    x_hi_n       = x_hi;
    wait_n       = wait_cnt;
    setup_n      = 1'b0;
    param_n      = 1'b0;
    loaded_n     = params_loaded;
    bank_n       = bnn_x_bank_hi;
    x_n          = bnn_x;
    y_data_n     = y_data;
    y_valid_n    = y_valid;
    case (state)
      IDLE, READY: begin
        if (cfg_start) begin
          state_n      = LOAD;
          loaded_n     = 1'b0;
          bytes_left_n = BW'(BYTES);
          bit_cnt_n    = '0;
        end else if (x_hs) begin
          state_n = X_LO;
          bank_n  = 1'b0;
          x_n     = x_data[3:0];
          x_hi_n  = x_data[7:4];
        end
      end
      LOAD: begin
        // bit_cnt counts bits still to be driven after the one now on param_in,
        // so a byte accepted during the last bit keeps the stream gapless.
        if (cfg_hs) begin
          setup_n      = 1'b1;
          param_n      = cfg_byte[7];
          shreg_n      = {cfg_byte[6:0], 1'b0};
          bit_cnt_n    = 3'd7;
          bytes_left_n = bytes_left - BW'(1);
        end else if (bit_cnt != '0) begin
          setup_n   = 1'b1;
          param_n   = shreg[7];
          shreg_n   = {shreg[6:0], 1'b0};
          bit_cnt_n = bit_cnt - 3'd1;
        end else if (bytes_left == '0) begin
          state_n  = READY;
          loaded_n = 1'b1;
        end
      end
      X_LO: begin
        state_n = X_HI;
        bank_n  = 1'b1;
        x_n     = x_hi;
      end
      X_HI: begin
        if (SETTLE == 0) begin
          state_n   = RESULT;
          y_data_n  = bnn_out;
          y_valid_n = 1'b1;
        end else begin
          state_n = WAIT;
          wait_n  = 4'(SETTLE) - 4'd1;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_n   = RESULT;
          y_data_n  = bnn_out;
          y_valid_n = 1'b1;
        end else begin
          wait_n = wait_cnt - 4'd1;
        end
      end
      RESULT: begin
        if (y_ready) begin
          state_n   = READY;
          y_valid_n = 1'b0;
          bank_n    = 1'b0;
          x_n       = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bytes_left    <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      x_hi          <= '0;
      wait_cnt      <= '0;
      cfg_ready     <= 1'b0;
      x_ready_q     <= 1'b0;
      busy          <= 1'b0;
      params_loaded <= 1'b0;
      bnn_setup     <= 1'b0;
      bnn_param_in  <= 1'b0;
      bnn_x_bank_hi <= 1'b0;
      bnn_x         <= '0;
      y_data        <= '0;
      y_valid       <= 1'b0;
    end else begin
      state         <= state_n;
      bytes_left    <= bytes_left_n;
      bit_cnt       <= bit_cnt_n;
      shreg         <= shreg_n;
      x_hi          <= x_hi_n;
      wait_cnt      <= wait_n;
      cfg_ready     <= (state_n == LOAD) && (bytes_left_n != '0) && (bit_cnt_n == '0);
      x_ready_q     <= (state_n == READY);
      busy          <= (state_n != IDLE) && (state_n != READY);
      params_loaded <= loaded_n;
      bnn_setup     <= setup_n;
      bnn_param_in  <= param_n;
      bnn_x_bank_hi <= bank_n;
      bnn_x         <= x_n;
      y_data        <= y_data_n;
      y_valid       <= y_valid_n;
    end
  end

endmodule
